// File: rtl/bus_arbiter_if.sv
// Shared types and the downstream bus interface for bus_arbiter.
//
// bus_arbiter_pkg
//   word_t             : 32-bit address/data word.
//   transaction_kind_t : debug tag carried with each access. KIND_NONE is
//                        the reset value.
//
// Bus_if (downstream MMU bus)
//   addr     : access address             (master -> slave)
//   wdata    : write data                 (master -> slave)
//   kind     : transaction debug tag      (master -> slave)
//   read_en  : read strobe, ACCESS only   (master -> slave)
//   write_en : write strobe, ACCESS only  (master -> slave)
//   rdata    : read data                  (slave -> master)

package bus_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_FETCH = 2'd1,
    KIND_DATA  = 2'd2,
    KIND_DEBUG = 2'd3
  } transaction_kind_t;

endpackage

interface Bus_if;
  import bus_arbiter_pkg::*;

  word_t             addr;
  word_t             wdata;
  word_t             rdata;
  transaction_kind_t kind;
  logic              read_en;
  logic              write_en;

  modport Master_side (
    output addr,
    output wdata,
    output kind,
    output read_en,
    output write_en,
    input  rdata
  );

  modport Slave_side (
    input  addr,
    input  wdata,
    input  kind,
    input  read_en,
    input  write_en,
    output rdata
  );

endinterface

// File: rtl/bus_arbiter.sv
// Two-master (CPU, DMA) arbiter in front of a single downstream bus.
// One transaction at a time: IDLE picks a winner and latches its request,
// ACCESS drives the bus for WAIT_CYCLES+1 cycles, DONE pulses the winner's
// done output for one cycle.
//
// Parameters
//   WAIT_CYCLES  : extra bus cycles per access (0..15).
//   STARVE_LIMIT : consecutive DMA grants with the CPU waiting before the
//                  CPU is forced onto the bus (1..255).
//
// Ports
//   clk, reset                     : clock, synchronous active-high reset.
//   cpu_req/we/addr/wdata/kind     : CPU request (level) and its payload.
//   cpu_rdata, cpu_done            : CPU read data (registered), done pulse.
//   dma_*                          : same set for the DMA master.
//   dma_lock                       : DMA wants back-to-back accesses.
//   bus                            : downstream bus, master side.
//   owner                          : 0=CPU, 1=DMA; current or latest grant.
//   busy                           : high in ACCESS and DONE.

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  word_t             cpu_addr,
  input  word_t             cpu_wdata,
  input  transaction_kind_t cpu_kind,
  output word_t             cpu_rdata,
  output logic              cpu_done,

  input  logic              dma_req,
  input  logic              dma_we,
  input  word_t             dma_addr,
  input  word_t             dma_wdata,
  input  transaction_kind_t dma_kind,
  output word_t             dma_rdata,
  output logic              dma_done,
  input  logic              dma_lock,

  Bus_if.Master_side        bus,

  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_e            state_q,     state_d;
  logic [3:0]        wait_q,      wait_d;
  logic [7:0]        starve_q,    starve_d;
  logic              owner_q,     owner_d;
  logic              we_q,        we_d;
  word_t             addr_q,      addr_d;
  word_t             wdata_q,     wdata_d;
  transaction_kind_t kind_q,      kind_d;
  word_t             cpu_rdata_q, cpu_rdata_d;
  word_t             dma_rdata_q, dma_rdata_d;

  logic              grant_cpu;
  logic              grant_dma;
  logic              starved;
  logic              lock_hold;

  // The CPU has waited through STARVE_MAX DMA grants and is still asking.
  assign starved   = cpu_req && (starve_q == STARVE_MAX);

  // A locked DMA burst keeps the bus through ordinary DMA priority; the
  // term is spelled out so the burst case stays visible in the grant logic.
  assign lock_hold = dma_lock && owner_q && dma_req;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    kind_d      = kind_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    grant_cpu   = 1'b0;
    grant_dma   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!cpu_req) begin
          starve_d = '0;
        end

        if (starved) begin
          grant_cpu = 1'b1;
        end else if (dma_req || lock_hold) begin
          grant_dma = 1'b1;
        end else if (cpu_req) begin
          grant_cpu = 1'b1;
        end

        if (grant_cpu) begin
          owner_d  = 1'b0;
          we_d     = cpu_we;
          addr_d   = cpu_addr;
          wdata_d  = cpu_wdata;
          kind_d   = cpu_kind;
          starve_d = '0;
          wait_d   = WAIT_INIT;
          state_d  = ST_ACCESS;
        end else if (grant_dma) begin
          owner_d  = 1'b1;
          we_d     = dma_we;
          addr_d   = dma_addr;
          wdata_d  = dma_wdata;
          kind_d   = dma_kind;
          // Count only grants that made a waiting CPU wait longer.
          if (cpu_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 8'd1;
          end
          wait_d   = WAIT_INIT;
          state_d  = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (wait_q == '0) begin
          // Last bus cycle: capture read data for the owner only.
          if (!we_q) begin
            if (owner_q) begin
              dma_rdata_d = bus.rdata;
            end else begin
              cpu_rdata_d = bus.rdata;
            end
          end
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its next value from the same pre-edge snapshot.
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      starve_q    <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      kind_q      <= KIND_NONE;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      kind_q      <= kind_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Address, data and tag always show the latched request so they hold
  // their last values between accesses; only the strobes are gated.
  assign bus.addr     = addr_q;
  assign bus.wdata    = wdata_q;
  assign bus.kind     = kind_q;
  assign bus.read_en  = (state_q == ST_ACCESS) && !we_q;
  assign bus.write_en = (state_q == ST_ACCESS) &&  we_q;

  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_done  = (state_q == ST_DONE) && !owner_q;
  assign dma_done  = (state_q == ST_DONE) &&  owner_q;
  assign owner     = owner_q;
  assign busy      = (state_q == ST_ACCESS) || (state_q == ST_DONE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter. Three instances:
//   u_a : WAIT_CYCLES=1, STARVE_LIMIT=2 (read, contention, input change,
//         starvation)
//   u_b : WAIT_CYCLES=0 (DMA read then write)
//   u_c : WAIT_CYCLES=3 (reset in the middle of an access)

module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance A ----------------
  logic a_cpu_req, a_cpu_we, a_dma_req, a_dma_we, a_dma_lock;
  word_t a_cpu_addr, a_cpu_wdata, a_dma_addr, a_dma_wdata;
  word_t a_cpu_rdata, a_dma_rdata;
  logic a_cpu_done, a_dma_done, a_owner, a_busy;
  Bus_if a_bus();

  bus_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(2)) u_a (
    .clk(clk), .reset(reset),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
    .cpu_wdata(a_cpu_wdata), .cpu_kind(KIND_FETCH),
    .cpu_rdata(a_cpu_rdata), .cpu_done(a_cpu_done),
    .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_addr(a_dma_addr),
    .dma_wdata(a_dma_wdata), .dma_kind(KIND_DEBUG),
    .dma_rdata(a_dma_rdata), .dma_done(a_dma_done), .dma_lock(a_dma_lock),
    .bus(a_bus), .owner(a_owner), .busy(a_busy)
  );

  // ---------------- instance B ----------------
  logic b_cpu_req, b_cpu_we, b_dma_req, b_dma_we, b_dma_lock;
  word_t b_cpu_addr, b_cpu_wdata, b_dma_addr, b_dma_wdata;
  word_t b_cpu_rdata, b_dma_rdata;
  logic b_cpu_done, b_dma_done, b_owner, b_busy;
  Bus_if b_bus();

  bus_arbiter #(.WAIT_CYCLES(0), .STARVE_LIMIT(8)) u_b (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_kind(KIND_FETCH),
    .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done),
    .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr),
    .dma_wdata(b_dma_wdata), .dma_kind(KIND_DATA),
    .dma_rdata(b_dma_rdata), .dma_done(b_dma_done), .dma_lock(b_dma_lock),
    .bus(b_bus), .owner(b_owner), .busy(b_busy)
  );

  // ---------------- instance C ----------------
  logic c_cpu_req, c_cpu_we, c_dma_req, c_dma_we, c_dma_lock;
  word_t c_cpu_addr, c_cpu_wdata, c_dma_addr, c_dma_wdata;
  word_t c_cpu_rdata, c_dma_rdata;
  logic c_cpu_done, c_dma_done, c_owner, c_busy;
  Bus_if c_bus();

  bus_arbiter #(.WAIT_CYCLES(3), .STARVE_LIMIT(8)) u_c (
    .clk(clk), .reset(reset),
    .cpu_req(c_cpu_req), .cpu_we(c_cpu_we), .cpu_addr(c_cpu_addr),
    .cpu_wdata(c_cpu_wdata), .cpu_kind(KIND_FETCH),
    .cpu_rdata(c_cpu_rdata), .cpu_done(c_cpu_done),
    .dma_req(c_dma_req), .dma_we(c_dma_we), .dma_addr(c_dma_addr),
    .dma_wdata(c_dma_wdata), .dma_kind(KIND_DEBUG),
    .dma_rdata(c_dma_rdata), .dma_done(c_dma_done), .dma_lock(c_dma_lock),
    .bus(c_bus), .owner(c_owner), .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One record per clock cycle of instance A.
  // in_f  = {cpu_req, cpu_we, dma_req, dma_we, dma_lock}
  // exp_f = {read_en, write_en, busy, owner, cpu_done, dma_done}
  typedef struct {
    logic [4:0]        in_f;
    word_t             cpu_addr;
    word_t             cpu_wdata;
    word_t             dma_addr;
    word_t             dma_wdata;
    word_t             slave_rdata;
    logic [5:0]        exp_f;
    word_t             exp_addr;
    word_t             exp_wdata;
    transaction_kind_t exp_kind;
    word_t             exp_crdata;
    word_t             exp_drdata;
  } vec_t;

  localparam int N_VEC = 19;
  vec_t vecs[N_VEC];

  int order[4];
  int n_grants;

  initial begin
    // CPU read, WAIT_CYCLES=1: read_en at t1-t2, done+rdata at t3.
    vecs[0]  = '{5'b10000, 32'h0300_0010, 0, 0, 0, 0,
                 6'b000000, 0, 0, KIND_NONE, 0, 0};
    vecs[1]  = '{5'b10000, 32'h0300_0010, 0, 0, 0, 32'h1111_1111,
                 6'b101000, 32'h0300_0010, 0, KIND_FETCH, 0, 0};
    vecs[2]  = '{5'b10000, 32'h0300_0010, 0, 0, 0, 32'hDEAD_BEEF,
                 6'b101000, 32'h0300_0010, 0, KIND_FETCH, 0, 0};
    vecs[3]  = '{5'b00000, 32'h0300_0010, 0, 0, 0, 0,
                 6'b001010, 32'h0300_0010, 0, KIND_FETCH, 32'hDEAD_BEEF, 0};
    vecs[4]  = '{5'b00000, 32'h0300_0010, 0, 0, 0, 0,
                 6'b000000, 32'h0300_0010, 0, KIND_FETCH, 32'hDEAD_BEEF, 0};
    // Contention: DMA first (done t3), CPU granted at t4 (done t7).
    vecs[5]  = '{5'b10100, 32'h0000_0100, 0, 32'h0000_0200, 0, 0,
                 6'b000000, 32'h0300_0010, 0, KIND_FETCH, 32'hDEAD_BEEF, 0};
    vecs[6]  = '{5'b10100, 32'h0000_0100, 0, 32'h0000_0200, 0, 32'hAAAA_0001,
                 6'b101100, 32'h0000_0200, 0, KIND_DEBUG, 32'hDEAD_BEEF, 0};
    vecs[7]  = '{5'b10100, 32'h0000_0100, 0, 32'h0000_0200, 0, 32'hAAAA_0002,
                 6'b101100, 32'h0000_0200, 0, KIND_DEBUG, 32'hDEAD_BEEF, 0};
    vecs[8]  = '{5'b10000, 32'h0000_0100, 0, 32'h0000_0200, 0, 0,
                 6'b001101, 32'h0000_0200, 0, KIND_DEBUG, 32'hDEAD_BEEF, 32'hAAAA_0002};
    vecs[9]  = '{5'b10000, 32'h0000_0100, 0, 32'h0000_0200, 0, 0,
                 6'b000100, 32'h0000_0200, 0, KIND_DEBUG, 32'hDEAD_BEEF, 32'hAAAA_0002};
    vecs[10] = '{5'b10000, 32'h0000_0100, 0, 0, 0, 32'hBBBB_0001,
                 6'b101000, 32'h0000_0100, 0, KIND_FETCH, 32'hDEAD_BEEF, 32'hAAAA_0002};
    vecs[11] = '{5'b10000, 32'h0000_0100, 0, 0, 0, 32'hBBBB_0002,
                 6'b101000, 32'h0000_0100, 0, KIND_FETCH, 32'hDEAD_BEEF, 32'hAAAA_0002};
    vecs[12] = '{5'b00000, 32'h0000_0100, 0, 0, 0, 0,
                 6'b001010, 32'h0000_0100, 0, KIND_FETCH, 32'hBBBB_0002, 32'hAAAA_0002};
    vecs[13] = '{5'b00000, 32'h0000_0100, 0, 0, 0, 0,
                 6'b000000, 32'h0000_0100, 0, KIND_FETCH, 32'hBBBB_0002, 32'hAAAA_0002};
    // CPU write; addr/we/wdata change one cycle after the grant.
    vecs[14] = '{5'b11000, 32'h0000_0010, 32'h0000_0055, 0, 0, 0,
                 6'b000000, 32'h0000_0100, 0, KIND_FETCH, 32'hBBBB_0002, 32'hAAAA_0002};
    vecs[15] = '{5'b10000, 32'h0000_0020, 32'h0000_0066, 0, 0, 32'hCCCC_0001,
                 6'b011000, 32'h0000_0010, 32'h0000_0055, KIND_FETCH, 32'hBBBB_0002, 32'hAAAA_0002};
    vecs[16] = '{5'b10000, 32'h0000_0020, 32'h0000_0066, 0, 0, 32'hCCCC_0002,
                 6'b011000, 32'h0000_0010, 32'h0000_0055, KIND_FETCH, 32'hBBBB_0002, 32'hAAAA_0002};
    vecs[17] = '{5'b00000, 32'h0000_0020, 32'h0000_0066, 0, 0, 0,
                 6'b001010, 32'h0000_0010, 32'h0000_0055, KIND_FETCH, 32'hBBBB_0002, 32'hAAAA_0002};
    vecs[18] = '{5'b00000, 32'h0000_0020, 32'h0000_0066, 0, 0, 0,
                 6'b000000, 32'h0000_0010, 32'h0000_0055, KIND_FETCH, 32'hBBBB_0002, 32'hAAAA_0002};

    {a_cpu_req, a_cpu_we, a_dma_req, a_dma_we, a_dma_lock} = '0;
    {b_cpu_req, b_cpu_we, b_dma_req, b_dma_we, b_dma_lock} = '0;
    {c_cpu_req, c_cpu_we, c_dma_req, c_dma_we, c_dma_lock} = '0;
    a_cpu_addr = '0; a_cpu_wdata = '0; a_dma_addr = '0; a_dma_wdata = '0;
    b_cpu_addr = '0; b_cpu_wdata = '0; b_dma_addr = '0; b_dma_wdata = '0;
    c_cpu_addr = '0; c_cpu_wdata = '0; c_dma_addr = '0; c_dma_wdata = '0;
    a_bus.rdata = '0;
    b_bus.rdata = '0;
    c_bus.rdata = '0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state of B and C (A is covered by table row 0).
    check("b_reset busy",      32'(b_busy), 0);
    check("b_reset owner",     32'(b_owner), 0);
    check("b_reset write_en",  32'(b_bus.write_en), 0);
    check("b_reset addr",      b_bus.addr, 0);
    check("b_reset kind",      32'(b_bus.kind), 32'(KIND_NONE));
    check("c_reset dma_rdata", c_dma_rdata, 0);
    check("c_reset read_en",   32'(c_bus.read_en), 0);
    check("c_reset starve",    32'(u_c.starve_q), 0);

    // ---------------- table-driven run on A ----------------
    for (int i = 0; i < N_VEC; i++) begin
      {a_cpu_req, a_cpu_we, a_dma_req, a_dma_we, a_dma_lock} = vecs[i].in_f;
      a_cpu_addr  = vecs[i].cpu_addr;
      a_cpu_wdata = vecs[i].cpu_wdata;
      a_dma_addr  = vecs[i].dma_addr;
      a_dma_wdata = vecs[i].dma_wdata;
      a_bus.rdata = vecs[i].slave_rdata;
      #1;
      check($sformatf("row%0d read_en", i),  32'(a_bus.read_en),  32'(vecs[i].exp_f[5]));
      check($sformatf("row%0d write_en", i), 32'(a_bus.write_en), 32'(vecs[i].exp_f[4]));
      check($sformatf("row%0d busy", i),     32'(a_busy),         32'(vecs[i].exp_f[3]));
      check($sformatf("row%0d owner", i),    32'(a_owner),        32'(vecs[i].exp_f[2]));
      check($sformatf("row%0d cpu_done", i), 32'(a_cpu_done),     32'(vecs[i].exp_f[1]));
      check($sformatf("row%0d dma_done", i), 32'(a_dma_done),     32'(vecs[i].exp_f[0]));
      check($sformatf("row%0d addr", i),     a_bus.addr,          vecs[i].exp_addr);
      check($sformatf("row%0d wdata", i),    a_bus.wdata,         vecs[i].exp_wdata);
      check($sformatf("row%0d kind", i),     32'(a_bus.kind),     32'(vecs[i].exp_kind));
      check($sformatf("row%0d cpu_rdata", i), a_cpu_rdata,        vecs[i].exp_crdata);
      check($sformatf("row%0d dma_rdata", i), a_dma_rdata,        vecs[i].exp_drdata);
      tick();
    end

    // ---------------- starvation on A (STARVE_LIMIT=2) ----------------
    // Expected grant order with DMA locked and the CPU waiting: D, D, C, D.
    a_cpu_req  = 1'b1;
    a_cpu_we   = 1'b0;
    a_dma_req  = 1'b1;
    a_dma_we   = 1'b0;
    a_dma_lock = 1'b1;
    n_grants   = 0;
    for (int cyc = 0; cyc < 60 && n_grants < 4; cyc++) begin
      tick();
      check("starve done_exclusive", 32'(a_cpu_done & a_dma_done), 0);
      if (a_cpu_done) begin
        order[n_grants] = 0;
        n_grants++;
        a_cpu_req = 1'b0;
      end else if (a_dma_done) begin
        order[n_grants] = 1;
        n_grants++;
      end
    end
    a_dma_req  = 1'b0;
    a_dma_lock = 1'b0;
    check("starve grant_count", n_grants, 4);
    if (n_grants == 4) begin
      check("starve grant0_dma", order[0], 1);
      check("starve grant1_dma", order[1], 1);
      check("starve grant2_cpu", order[2], 0);
      check("starve grant3_dma", order[3], 1);
    end
    tick();

    // ---------------- B: WAIT_CYCLES=0, DMA read then write ----------------
    b_dma_req   = 1'b1;
    b_dma_we    = 1'b0;
    b_dma_addr  = 32'h0600_0004;
    b_bus.rdata = 32'h0BAD_F00D;
    check("b_rd t0 read_en", 32'(b_bus.read_en), 0);
    tick();
    check("b_rd t1 read_en", 32'(b_bus.read_en), 1);
    check("b_rd t1 owner",   32'(b_owner), 1);
    tick();
    check("b_rd t2 dma_done",  32'(b_dma_done), 1);
    check("b_rd t2 dma_rdata", b_dma_rdata, 32'h0BAD_F00D);
    check("b_rd t2 cpu_done",  32'(b_cpu_done), 0);
    b_dma_req = 1'b0;
    tick();
    b_dma_req   = 1'b1;
    b_dma_we    = 1'b1;
    b_dma_addr  = 32'h0600_0000;
    b_dma_wdata = 32'h1234_5678;
    b_bus.rdata = 32'hFFFF_FFFF;
    check("b_wr t0 write_en", 32'(b_bus.write_en), 0);
    tick();
    check("b_wr t1 write_en", 32'(b_bus.write_en), 1);
    check("b_wr t1 read_en",  32'(b_bus.read_en), 0);
    check("b_wr t1 addr",     b_bus.addr, 32'h0600_0000);
    check("b_wr t1 wdata",    b_bus.wdata, 32'h1234_5678);
    check("b_wr t1 dma_done", 32'(b_dma_done), 0);
    tick();
    check("b_wr t2 write_en",  32'(b_bus.write_en), 0);
    check("b_wr t2 dma_done",  32'(b_dma_done), 1);
    check("b_wr t2 dma_rdata", b_dma_rdata, 32'h0BAD_F00D);
    b_dma_req = 1'b0;
    tick();
    check("b_wr t3 dma_done", 32'(b_dma_done), 0);
    check("b_wr t3 busy",     32'(b_busy), 0);

    // ---------------- C: WAIT_CYCLES=3, reset in 2nd ACCESS cycle ----------
    c_cpu_req   = 1'b1;
    c_cpu_we    = 1'b0;
    c_cpu_addr  = 32'h0300_0020;
    c_bus.rdata = 32'h7777_7777;
    check("c t0 busy", 32'(c_busy), 0);
    tick();
    check("c t1 read_en", 32'(c_bus.read_en), 1);
    tick();
    check("c t2 read_en", 32'(c_bus.read_en), 1);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    c_cpu_req = 1'b0;
    check("c t3 read_en",   32'(c_bus.read_en), 0);
    check("c t3 write_en",  32'(c_bus.write_en), 0);
    check("c t3 busy",      32'(c_busy), 0);
    check("c t3 cpu_done",  32'(c_cpu_done), 0);
    check("c t3 cpu_rdata", c_cpu_rdata, 0);
    check("c t3 state",     32'(u_c.state_q), 0);
    check("c t3 wait_cnt",  32'(u_c.wait_q), 0);
    check("c t3 starve",    32'(u_c.starve_q), 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("c post%0d cpu_done", k), 32'(c_cpu_done), 0);
      check($sformatf("c post%0d read_en", k),  32'(c_bus.read_en), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
